// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back buffer feeding the register file, with pending-write forwarding lookup
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic [AW-1:0]           ex_addr_i,
    input  logic [DW-1:0]           ex_data_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [AW-1:0]           mem_addr_i,
    input  logic [DW-1:0]           mem_data_i,
    input  logic                    hold_i,
    output logic                    rd_wena_o,
    output logic [AW-1:0]           rd_addr_o,
    output logic [DW-1:0]           rd_data_o,
    input  logic [AW-1:0]           rs_addr_i,
    output logic                    rs_hit_o,
    output logic [DW-1:0]           rs_data_o,
    input  logic [AW-1:0]           rt_addr_i,
    output logic                    rt_hit_o,
    output logic [DW-1:0]           rt_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_n;
    logic [PW-1:0]    head_q, tail_q, ex_slot;
    logic [CW-1:0]    count_q, free;
    logic             mem_push, ex_push, pop;

    // Youngest matching valid entry wins: scan oldest to youngest, letting later matches overwrite.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (a != '0 && valid_q[idx] && addr_q[idx] == a) r = {1'b1, data_q[idx]};
        end
        return r;
    endfunction

    // Handshakes use registered occupancy only; MEM (older) takes the tail slot before EX.
    always_comb begin
        free        = CW'(DEPTH) - count_q;
        mem_ready_o = free >= CW'(1);
        ex_ready_o  = free >= CW'(2) || (free == CW'(1) && !mem_valid_i);
        mem_push    = mem_valid_i && mem_ready_o && mem_addr_i != '0;
        ex_push     = ex_valid_i && ex_ready_o && ex_addr_i != '0;
        ex_slot     = tail_q + PW'(mem_push);
        count_o     = count_q;
        empty_o     = count_q == '0;
        full_o      = count_q == CW'(DEPTH);
        rd_wena_o   = !empty_o && !hold_i;
        pop         = rd_wena_o;
        rd_addr_o   = rd_wena_o ? addr_q[head_q] : '0;
        rd_data_o   = rd_wena_o ? data_q[head_q] : '0;
        valid_n     = valid_q;
        if (pop) valid_n[head_q] = 1'b0;
        if (mem_push) valid_n[tail_q] = 1'b1;
        if (ex_push) valid_n[ex_slot] = 1'b1;
    end

    // Forwarding lookups for both decode read ports.
    always_comb {rs_hit_o, rs_data_o} = lookup(rs_addr_i);
    always_comb {rt_hit_o, rt_data_o} = lookup(rt_addr_i);

    // Pointer, occupancy and valid-bit state; reset discards every pending entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(mem_push) + PW'(ex_push);
            count_q <= count_q + CW'(mem_push) + CW'(ex_push) - CW'(pop);
            valid_q <= valid_n;
        end
    end

    // Entry payload storage; contents only matter while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (mem_push) begin
            addr_q[tail_q] <= mem_addr_i;
            data_q[tail_q] <= mem_data_i;
        end
        if (ex_push) begin
            addr_q[ex_slot] <= ex_addr_i;
            data_q[ex_slot] <= ex_data_i;
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: queue-model checker plus directed scenarios for wb_write_queue
module tb_wb_write_queue;
    localparam int DEPTH = 4, AW = 5, DW = 32, CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ex_valid = 1'b0, mem_valid = 1'b0, hold = 1'b0;
    logic [AW-1:0] ex_addr = '0, mem_addr = '0, rs_addr = '0, rt_addr = '0;
    logic [DW-1:0] ex_data = '0, mem_data = '0;
    logic ex_ready, mem_ready, rd_wena, rs_hit, rt_hit, full, empty;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, rs_data, rt_data;
    logic [CW-1:0] count;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
        .hold_i(hold), .rd_wena_o(rd_wena), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
        .rs_addr_i(rs_addr), .rs_hit_o(rs_hit), .rs_data_o(rs_data),
        .rt_addr_i(rt_addr), .rt_hit_o(rt_hit), .rt_data_o(rt_data),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
    ent_t q[$];
    ent_t wlog[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != '0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].a == a) begin
                    h = 1'b1;
                    d = q[i].d;
                    break;
                end
    endfunction

    // Model: pending writes as a FIFO in program order, updated at each edge from the inputs seen there.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else begin : upd
            int f;
            bit mr, er, pop;
            f   = DEPTH - q.size();
            mr  = mem_valid && f >= 1;
            er  = ex_valid && (f >= 2 || (f == 1 && !mem_valid));
            pop = q.size() > 0 && !hold;
            if (pop) void'(q.pop_front());
            if (mr && mem_addr != 0) q.push_back(ent_t'{mem_addr, mem_data});
            if (er && ex_addr != 0) q.push_back(ent_t'{ex_addr, ex_data});
        end
    end

    // Compare every output against the model mid-cycle, and log the writes the DUT performs.
    always @(negedge clk) begin : cmp
        int f;
        logic we, h;
        logic [DW-1:0] d;
        f  = DEPTH - q.size();
        we = q.size() > 0 && !hold;
        chk("mem_ready", mem_ready, f >= 1);
        chk("ex_ready", ex_ready, f >= 2 || (f == 1 && !mem_valid));
        chk("rd_wena", rd_wena, we);
        chk("rd_addr", rd_addr, we ? q[0].a : 0);
        chk("rd_data", rd_data, we ? q[0].d : 0);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        model_lookup(rs_addr, h, d);
        chk("rs_hit", rs_hit, h);
        chk("rs_data", rs_data, d);
        model_lookup(rt_addr, h, d);
        chk("rt_hit", rt_hit, h);
        chk("rt_data", rt_data, d);
        if (rd_wena === 1'b1) wlog.push_back(ent_t'{rd_addr, rd_data});
    end

    task automatic drive(input bit mv, input int ma, input logic [DW-1:0] md,
                         input bit ev, input int ea, input logic [DW-1:0] ed, input bit h);
        mem_valid = mv; mem_addr = AW'(ma); mem_data = md;
        ex_valid = ev; ex_addr = AW'(ea); ex_data = ed; hold = h;
        #1;
    endtask

    task automatic idle(input bit h);
        drive(0, 0, 0, 0, 0, 0, h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_a[15] = '{8, 5, 5, 1, 2, 3, 4, 7, 10, 11, 12, 13, 14, 15, 16};
    logic [DW-1:0] exp_d[15] = '{32'h1234, 32'hA, 32'hB, 32'h11, 32'h22, 32'h33, 32'h44, 32'h77,
                                 32'hD00A, 32'hD00B, 32'hD00C, 32'hD00D, 32'hD00E, 32'hD00F, 32'hD010};

    initial begin
        #1;
        chk("lit_rst_wena", rd_wena, 0);
        chk("lit_rst_empty", empty, 1);
        chk("lit_rst_full", full, 0);
        tick(); tick();
        rst_n = 1'b1;
        // single EX push, one-cycle latency to the write port
        drive(0, 0, 0, 1, 8, 32'h1234, 0);
        chk("lit_ex_ready_empty", ex_ready, 1);
        tick();
        idle(0);
        chk("lit_first_wena", rd_wena, 1);
        chk("lit_first_addr", rd_addr, 8);
        chk("lit_first_data", rd_data, 32'h1234);
        tick();
        chk("lit_first_empty", empty, 1);
        // same-cycle MEM/EX to one register: EX is younger
        drive(1, 5, 32'hA, 1, 5, 32'hB, 1);
        tick();
        rs_addr = 5; rt_addr = 5;
        idle(1);
        chk("lit_pair_count", count, 2);
        chk("lit_pair_hit", rs_hit, 1);
        chk("lit_pair_data", rs_data, 32'hB);
        tick();
        idle(0);
        chk("lit_pair_w0", rd_data, 32'hA);
        tick();
        chk("lit_pair_w1", rd_data, 32'hB);
        tick();
        rs_addr = 2; rt_addr = 4;
        // fill under hold, then the one-free-slot rule
        drive(1, 1, 32'h11, 1, 2, 32'h22, 1); tick();
        drive(1, 3, 32'h33, 0, 0, 0, 1); tick();
        drive(1, 4, 32'h44, 1, 6, 32'h66, 1);
        chk("lit_f1_mem_ready", mem_ready, 1);
        chk("lit_f1_ex_ready", ex_ready, 0);
        tick();
        drive(1, 7, 32'h77, 1, 9, 32'h99, 1);
        chk("lit_full_count", count, 4);
        chk("lit_full", full, 1);
        chk("lit_full_mem_ready", mem_ready, 0);
        chk("lit_full_ex_ready", ex_ready, 0);
        tick();
        drive(1, 7, 32'h77, 1, 9, 32'h99, 0);
        chk("lit_nocredit_mem", mem_ready, 0);
        chk("lit_nocredit_wena", rd_wena, 1);
        tick();
        chk("lit_after_drain_count", count, 3);
        chk("lit_after_drain_mem", mem_ready, 1);
        chk("lit_after_drain_ex", ex_ready, 0);
        tick();
        idle(0);
        repeat (4) tick();
        // zero destination is accepted but never enqueued
        rs_addr = 0; rt_addr = 0;
        drive(0, 0, 0, 1, 0, 32'hFFFF, 0);
        chk("lit_zero_ready", ex_ready, 1);
        tick();
        idle(0);
        chk("lit_zero_count", count, 0);
        chk("lit_zero_wena", rd_wena, 0);
        chk("lit_zero_hit", rs_hit, 0);
        // pointer wrap with hold pulsing
        rs_addr = 12; rt_addr = 14;
        drive(1, 10, 32'hD00A, 1, 11, 32'hD00B, 1); tick();
        drive(1, 12, 32'hD00C, 1, 13, 32'hD00D, 1); tick();
        idle(0); tick();
        idle(1); tick();
        idle(0); tick(); tick();
        drive(1, 14, 32'hD00E, 1, 15, 32'hD00F, 1); tick();
        drive(0, 0, 0, 1, 16, 32'hD010, 0);
        chk("lit_wrap_hit", rt_hit, 1);
        chk("lit_wrap_data", rt_data, 32'hD00E);
        tick();
        idle(0);
        repeat (4) tick();
        // asynchronous reset with two entries pending
        rs_addr = 20;
        drive(1, 20, 32'h1, 1, 21, 32'h2, 1); tick();
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_arst_count", count, 0);
        chk("lit_arst_empty", empty, 1);
        chk("lit_arst_hit", rs_hit, 0);
        idle(0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("lit_nwrites", wlog.size(), 15);
        for (int i = 0; i < 15 && i < wlog.size(); i++) begin
            chk($sformatf("lit_w%0d_addr", i), wlog[i].a, exp_a[i]);
            chk($sformatf("lit_w%0d_data", i), wlog[i].d, exp_d[i]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
